// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch control: button/UART command arbitration, run/stop/clear FSM,
// lap capture with a saturating lap counter, and live/lap display mux.
module stopwatch_lap_ctrl #(
  parameter int unsigned LAP_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_runstop,
  input  logic                 btn_clear,
  input  logic                 btn_lap,
  input  logic [7:0]           uart_rx,
  input  logic                 uart_rx_done,
  input  logic [6:0]           msec,
  input  logic [5:0]           sec,
  input  logic [5:0]           min,
  input  logic [4:0]           hour,
  output logic                 o_runstop,
  output logic                 o_clear,
  output logic [6:0]           disp_msec,
  output logic [5:0]           disp_sec,
  output logic [5:0]           disp_min,
  output logic [4:0]           disp_hour,
  output logic                 lap_active,
  output logic [LAP_CNT_W-1:0] lap_count
);

  typedef enum logic [1:0] {CmdNone, CmdRunStop, CmdClear, CmdLap} cmd_e;
  typedef enum logic [2:0] {StStop, StRun, StLapRun, StLapStop, StClr} state_e;

  localparam logic [LAP_CNT_W-1:0] LapMax = '1;
  localparam logic [LAP_CNT_W-1:0] LapOne = LAP_CNT_W'(1);

  state_e     state_q, state_d;
  cmd_e       pend_q, pend_d;
  cmd_e       uart_cmd, btn_cmd, exec_cmd;
  logic       capture, clear_laps;
  logic [6:0] lap_msec_q;
  logic [5:0] lap_sec_q;
  logic [5:0] lap_min_q;
  logic [4:0] lap_hour_q;

  // Unrecognised bytes decode to CmdNone and so never reach the pending slot.
  always_comb begin
    uart_cmd = CmdNone;
    if (uart_rx_done) begin
      unique case (uart_rx)
        8'h52, 8'h72: uart_cmd = CmdRunStop;
        8'h43, 8'h63: uart_cmd = CmdClear;
        8'h4C, 8'h6C: uart_cmd = CmdLap;
        default:      uart_cmd = CmdNone;
      endcase
    end
  end

  always_comb begin
    btn_cmd = CmdNone;
    if (btn_runstop)    btn_cmd = CmdRunStop;
    else if (btn_clear) btn_cmd = CmdClear;
    else if (btn_lap)   btn_cmd = CmdLap;
  end

  // Buttons win; UART waits in a 1-deep slot, newest UART command wins the slot.
  always_comb begin
    exec_cmd = CmdNone;
    pend_d   = pend_q;
    if (state_q == StClr) begin
      if (uart_cmd != CmdNone) pend_d = uart_cmd;
    end else if (btn_cmd != CmdNone) begin
      exec_cmd = btn_cmd;
      if (uart_cmd != CmdNone) pend_d = uart_cmd;
    end else if (pend_q != CmdNone) begin
      exec_cmd = pend_q;
      pend_d   = uart_cmd;
    end else begin
      exec_cmd = uart_cmd;
    end
  end

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    clear_laps = 1'b0;
    unique case (state_q)
      StStop: begin
        if (exec_cmd == CmdRunStop) begin
          state_d = StRun;
        end else if (exec_cmd == CmdClear) begin
          state_d    = StClr;
          clear_laps = 1'b1;
        end
      end
      StRun: begin
        if (exec_cmd == CmdRunStop) begin
          state_d = StStop;
        end else if (exec_cmd == CmdLap) begin
          state_d = StLapRun;
          capture = 1'b1;
        end
      end
      StLapRun: begin
        if (exec_cmd == CmdLap)           capture = 1'b1;
        else if (exec_cmd == CmdRunStop)  state_d = StLapStop;
        else if (exec_cmd == CmdClear)    state_d = StRun;
      end
      StLapStop: begin
        if (exec_cmd == CmdRunStop)       state_d = StLapRun;
        else if (exec_cmd == CmdClear)    state_d = StStop;
      end
      StClr:   state_d = StStop;
      default: state_d = StStop;
    endcase
  end

  // Outputs are registered from the next state so they follow the execute edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StStop;
      pend_q     <= CmdNone;
      o_runstop  <= 1'b0;
      o_clear    <= 1'b0;
      lap_active <= 1'b0;
      lap_count  <= '0;
      lap_msec_q <= '0;
      lap_sec_q  <= '0;
      lap_min_q  <= '0;
      lap_hour_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      o_runstop  <= (state_d == StRun) || (state_d == StLapRun);
      o_clear    <= (state_d == StClr);
      lap_active <= (state_d == StLapRun) || (state_d == StLapStop);
      if (clear_laps) begin
        lap_count  <= '0;
        lap_msec_q <= '0;
        lap_sec_q  <= '0;
        lap_min_q  <= '0;
        lap_hour_q <= '0;
      end else if (capture) begin
        if (lap_count != LapMax) lap_count <= lap_count + LapOne;
        lap_msec_q <= msec;
        lap_sec_q  <= sec;
        lap_min_q  <= min;
        lap_hour_q <= hour;
      end
    end
  end

  always_comb begin
    if (lap_active) begin
      disp_msec = lap_msec_q;
      disp_sec  = lap_sec_q;
      disp_min  = lap_min_q;
      disp_hour = lap_hour_q;
    end else begin
      disp_msec = msec;
      disp_sec  = sec;
      disp_min  = min;
      disp_hour = hour;
    end
  end

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl: FSM, arbitration, lap capture and
// saturation, clear cycle handling and mid-run reset.
module tb_stopwatch_lap_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_runstop = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
  logic [7:0] uart_rx = 8'h00;
  logic       uart_rx_done = 1'b0;
  logic [6:0] msec = '0;
  logic [5:0] sec = '0, min = '0;
  logic [4:0] hour = '0;
  logic       o_runstop, o_clear, lap_active;
  logic [6:0] disp_msec;
  logic [5:0] disp_sec, disp_min;
  logic [4:0] disp_hour;
  logic [3:0] lap_count;

  int tests_run = 0;
  int tests_failed = 0;

  stopwatch_lap_ctrl #(.LAP_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .btn_runstop(btn_runstop), .btn_clear(btn_clear),
    .btn_lap(btn_lap), .uart_rx(uart_rx), .uart_rx_done(uart_rx_done),
    .msec(msec), .sec(sec), .min(min), .hour(hour),
    .o_runstop(o_runstop), .o_clear(o_clear),
    .disp_msec(disp_msec), .disp_sec(disp_sec), .disp_min(disp_min),
    .disp_hour(disp_hour), .lap_active(lap_active), .lap_count(lap_count)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic rs, input logic cl, input logic lp,
                       input logic [7:0] rx, input logic rxv);
    btn_runstop = rs; btn_clear = cl; btn_lap = lp;
    uart_rx = rx; uart_rx_done = rxv;
    @(posedge clk); #1;
    btn_runstop = 0; btn_clear = 0; btn_lap = 0; uart_rx_done = 0;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_reset();
    rst = 1;
    idle(); idle();
    rst = 0;
    tests_run++; if (o_runstop !== 1'b0) begin tests_failed++; $display("FAIL rst_runstop: got %b want 0", o_runstop); end
    tests_run++; if (o_clear !== 1'b0) begin tests_failed++; $display("FAIL rst_clear: got %b want 0", o_clear); end
    tests_run++; if (lap_active !== 1'b0) begin tests_failed++; $display("FAIL rst_lap_active: got %b want 0", lap_active); end
    tests_run++; if (lap_count !== 4'd0) begin tests_failed++; $display("FAIL rst_lap_count: got %0d want 0", lap_count); end
  endtask

  task automatic test_runstop();
    cycle(1, 0, 0, 8'h00, 0);
    tests_run++; if (o_runstop !== 1'b1) begin tests_failed++; $display("FAIL rs_start: got %b want 1", o_runstop); end
    cycle(1, 0, 0, 8'h00, 0);
    tests_run++; if (o_runstop !== 1'b0) begin tests_failed++; $display("FAIL rs_stop: got %b want 0", o_runstop); end
    cycle(0, 1, 0, 8'h00, 0);
    tests_run++; if (o_clear !== 1'b1) begin tests_failed++; $display("FAIL clr_pulse: got %b want 1", o_clear); end
    idle();
    tests_run++; if (o_clear !== 1'b0) begin tests_failed++; $display("FAIL clr_one_cycle: got %b want 0", o_clear); end
    tests_run++; if (o_runstop !== 1'b0) begin tests_failed++; $display("FAIL clr_to_stop: got %b want 0", o_runstop); end
  endtask

  task automatic test_lap();
    cycle(1, 0, 0, 8'h00, 0);
    msec = 7'd42; sec = 6'd5; min = 6'd0; hour = 5'd0;
    cycle(0, 0, 1, 8'h00, 0);
    msec = 7'd50; sec = 6'd6;
    #1;
    tests_run++; if (lap_active !== 1'b1) begin tests_failed++; $display("FAIL lap_active: got %b want 1", lap_active); end
    tests_run++; if (lap_count !== 4'd1) begin tests_failed++; $display("FAIL lap_count1: got %0d want 1", lap_count); end
    tests_run++; if (disp_sec !== 6'd5 || disp_msec !== 7'd42)
      begin tests_failed++; $display("FAIL lap_frozen: got %0d.%0d want 5.42", disp_sec, disp_msec); end
    cycle(0, 1, 0, 8'h00, 0);
    tests_run++; if (lap_active !== 1'b0) begin tests_failed++; $display("FAIL unfreeze: got %b want 0", lap_active); end
    tests_run++; if (o_runstop !== 1'b1 || o_clear !== 1'b0)
      begin tests_failed++; $display("FAIL unfreeze_run: got run=%b clr=%b want 1 0", o_runstop, o_clear); end
    tests_run++; if (disp_msec !== 7'd50) begin tests_failed++; $display("FAIL disp_live: got %0d want 50", disp_msec); end
  endtask

  task automatic test_uart();
    cycle(0, 0, 0, 8'h72, 1);
    tests_run++; if (o_runstop !== 1'b0) begin tests_failed++; $display("FAIL uart_r_stop: got %b want 0", o_runstop); end
    cycle(0, 0, 0, 8'h41, 1);
    idle();
    tests_run++; if (o_runstop !== 1'b0 || o_clear !== 1'b0)
      begin tests_failed++; $display("FAIL uart_ignore: got run=%b clr=%b want 0 0", o_runstop, o_clear); end
    cycle(0, 0, 0, 8'h63, 1);
    tests_run++; if (o_clear !== 1'b1) begin tests_failed++; $display("FAIL uart_c_clear: got %b want 1", o_clear); end
    tests_run++; if (lap_count !== 4'd0) begin tests_failed++; $display("FAIL clr_laps: got %0d want 0", lap_count); end
    idle();
  endtask

  task automatic test_arbitration();
    cycle(1, 0, 0, 8'h43, 1);
    tests_run++; if (o_runstop !== 1'b1) begin tests_failed++; $display("FAIL arb_btn_first: got %b want 1", o_runstop); end
    idle();
    tests_run++; if (o_runstop !== 1'b1 || o_clear !== 1'b0)
      begin tests_failed++; $display("FAIL arb_clr_in_run: got run=%b clr=%b want 1 0", o_runstop, o_clear); end
    cycle(0, 0, 1, 8'h00, 0);
    cycle(1, 0, 0, 8'h63, 1);
    tests_run++; if (o_runstop !== 1'b0 || lap_active !== 1'b1)
      begin tests_failed++; $display("FAIL arb_lap_stop: got run=%b lap=%b want 0 1", o_runstop, lap_active); end
    idle();
    tests_run++; if (lap_active !== 1'b0 || o_runstop !== 1'b0 || lap_count !== 4'd1)
      begin tests_failed++; $display("FAIL arb_to_stop: got lap=%b run=%b cnt=%0d want 0 0 1", lap_active, o_runstop, lap_count); end
    // All three buttons: runstop wins.
    cycle(1, 1, 1, 8'h00, 0);
    tests_run++; if (o_runstop !== 1'b1 || o_clear !== 1'b0)
      begin tests_failed++; $display("FAIL prio_all: got run=%b clr=%b want 1 0", o_runstop, o_clear); end
    cycle(0, 1, 1, 8'h00, 0);
    tests_run++; if (lap_active !== 1'b0) begin tests_failed++; $display("FAIL prio_clr_lap: got %b want 0", lap_active); end
    cycle(1, 0, 0, 8'h00, 0);
    // Pending R executes before fresh L; L then takes the slot.
    cycle(0, 0, 1, 8'h52, 1);
    tests_run++; if (o_runstop !== 1'b0) begin tests_failed++; $display("FAIL pend_hold: got %b want 0", o_runstop); end
    cycle(0, 0, 0, 8'h4C, 1);
    tests_run++; if (o_runstop !== 1'b1 || lap_active !== 1'b0)
      begin tests_failed++; $display("FAIL pend_first: got run=%b lap=%b want 1 0", o_runstop, lap_active); end
    idle();
    tests_run++; if (lap_active !== 1'b1 || lap_count !== 4'd2)
      begin tests_failed++; $display("FAIL fresh_next: got lap=%b cnt=%0d want 1 2", lap_active, lap_count); end
    cycle(0, 0, 0, 8'h43, 1);
    cycle(1, 0, 0, 8'h00, 0);
    // Newer UART command overwrites the slot.
    cycle(0, 0, 1, 8'h52, 1);
    cycle(0, 0, 1, 8'h43, 1);
    idle();
    tests_run++; if (o_clear !== 1'b1 || o_runstop !== 1'b0)
      begin tests_failed++; $display("FAIL pend_overwrite: got clr=%b run=%b want 1 0", o_clear, o_runstop); end
    idle();
    tests_run++; if (lap_count !== 4'd0 || o_clear !== 1'b0)
      begin tests_failed++; $display("FAIL overwrite_end: got cnt=%0d clr=%b want 0 0", lap_count, o_clear); end
  endtask

  task automatic test_clr_cycle();
    cycle(0, 1, 0, 8'h00, 0);
    cycle(1, 0, 0, 8'h00, 0);
    tests_run++; if (o_runstop !== 1'b0 || o_clear !== 1'b0)
      begin tests_failed++; $display("FAIL clr_btn_drop: got run=%b clr=%b want 0 0", o_runstop, o_clear); end
    idle();
    tests_run++; if (o_runstop !== 1'b0) begin tests_failed++; $display("FAIL clr_btn_gone: got %b want 0", o_runstop); end
    cycle(0, 1, 0, 8'h00, 0);
    cycle(0, 0, 0, 8'h52, 1);
    tests_run++; if (o_runstop !== 1'b0) begin tests_failed++; $display("FAIL clr_uart_wait: got %b want 0", o_runstop); end
    idle();
    tests_run++; if (o_runstop !== 1'b1) begin tests_failed++; $display("FAIL clr_uart_pend: got %b want 1", o_runstop); end
    cycle(1, 0, 0, 8'h00, 0);
  endtask

  task automatic test_saturation();
    cycle(1, 0, 0, 8'h00, 0);
    for (int i = 1; i <= 17; i++) begin
      msec = 7'(i); sec = 6'(i); min = 6'(i); hour = 5'(i);
      cycle(0, 0, 1, 8'h00, 0);
      if (i == 15) begin
        tests_run++; if (lap_count !== 4'd15) begin tests_failed++; $display("FAIL sat_reach: got %0d want 15", lap_count); end
      end
    end
    msec = '0; sec = '0; min = '0; hour = '0;
    #1;
    tests_run++; if (lap_count !== 4'd15) begin tests_failed++; $display("FAIL sat_hold: got %0d want 15", lap_count); end
    tests_run++; if (disp_msec !== 7'd17 || disp_sec !== 6'd17 || disp_min !== 6'd17 || disp_hour !== 5'd17)
      begin tests_failed++; $display("FAIL sat_snapshot: got %0d:%0d:%0d.%0d want 17:17:17.17", disp_hour, disp_min, disp_sec, disp_msec); end
  endtask

  task automatic test_reset_mid();
    msec = 7'd33;
    cycle(0, 0, 1, 8'h52, 1);
    rst = 1;
    idle();
    rst = 0;
    tests_run++; if (o_runstop !== 1'b0 || o_clear !== 1'b0 || lap_active !== 1'b0 || lap_count !== 4'd0)
      begin tests_failed++; $display("FAIL mid_rst: got run=%b clr=%b lap=%b cnt=%0d want 0 0 0 0", o_runstop, o_clear, lap_active, lap_count); end
    tests_run++; if (disp_msec !== 7'd33) begin tests_failed++; $display("FAIL mid_rst_disp: got %0d want 33", disp_msec); end
    idle();
    tests_run++; if (o_runstop !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_pend: got %b want 0", o_runstop); end
  endtask

  initial begin
    test_reset();
    test_runstop();
    test_lap();
    test_uart();
    test_arbitration();
    test_clr_cycle();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap_ctrl.md
Name: stopwatch_lap_ctrl

Overview:
Control unit that sequences the stopwatch datapath (run/stop, clear) and adds lap capture. It accepts commands from three pre-debounced button pulses and from UART received bytes, and arbitrates between the two sources. It captures lap snapshots of the datapath time outputs and drives a display mux that selects either live time or the frozen lap value. It sits between the button/UART front end and the stopwatch datapath and display.

Parameters:
LAP_CNT_W, 4, width of the lap counter; the counter saturates at 2^LAP_CNT_W-1.

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
btn_runstop  input  1  one-cycle debounced pulse: toggle run/stop
btn_clear  input  1  one-cycle debounced pulse: clear / exit lap
btn_lap  input  1  one-cycle debounced pulse: capture lap
uart_rx  input  8  received UART byte
uart_rx_done  input  1  one-cycle strobe; uart_rx is valid while this is high
msec  input  7  live datapath msec (0..99)
sec  input  6  live datapath sec
min  input  6  live datapath min
hour  input  5  live datapath hour
o_runstop  output  1  to datapath; 1 = counting
o_clear  output  1  to datapath; one-cycle clear pulse
disp_msec  output  7  displayed msec
disp_sec  output  6  displayed sec
disp_min  output  6  displayed min
disp_hour  output  5  displayed hour
lap_active  output  1  1 = display shows the frozen lap value
lap_count  output  LAP_CNT_W  number of laps taken since the last clear

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. Reset forces state STOP, o_runstop=0, o_clear=0, lap_active=0, lap_count=0, lap registers=0, UART pending=empty.
- UART decode: active only when uart_rx_done=1.
  - 0x52 or 0x72 ('R'/'r') = RUNSTOP.
  - 0x43 or 0x63 ('C'/'c') = CLEAR.
  - 0x4C or 0x6C ('L'/'l') = LAP.
  - Any other byte is ignored and never occupies the pending slot.
- Command arbitration (at most one command is executed per cycle):
  - Button priority: btn_runstop > btn_clear > btn_lap. If several buttons pulse in the same cycle, only the highest-priority one executes and the others are dropped.
  - A decoded UART command executes only in a cycle with no button pulse. If a button pulse occurs in the same cycle, the UART command goes into a 1-deep pending slot and executes in the first later cycle with no button pulse.
  - A newer decoded UART command overwrites the pending slot.
  - The pending command executes before a fresh UART command arriving in the same cycle; the fresh command then takes the slot.
- FSM (state names fixed; transitions are on the executed command only):
  - STOP (run=0, lap_active=0):
    - RUNSTOP -> RUN.
    - CLEAR -> CLR.
    - LAP ignored.
  - RUN (run=1, lap_active=0):
    - RUNSTOP -> STOP.
    - LAP -> capture lap, lap_count+1, go to LAP_RUN.
    - CLEAR ignored.
  - LAP_RUN (run=1, lap_active=1):
    - LAP -> recapture, lap_count+1, stay.
    - RUNSTOP -> LAP_STOP.
    - CLEAR -> RUN (unfreeze only; datapath is not cleared).
  - LAP_STOP (run=0, lap_active=1):
    - RUNSTOP -> LAP_RUN.
    - CLEAR -> STOP (unfreeze only).
    - LAP ignored.
  - CLR (run=0, o_clear=1 for exactly this one cycle):
    - Clears lap_count and the lap registers.
    - Unconditionally goes to STOP next cycle.
    - Button commands arriving in the CLR cycle are dropped. A UART command arriving in the CLR cycle is pended.
- Timing:
  - o_runstop, o_clear and lap_active are registered from the state: a command executed at edge N takes effect at outputs after edge N.
  - Lap capture samples msec/sec/min/hour at the execute edge.
- Display: disp_* = lap registers when lap_active=1, else the live inputs (combinational mux, zero added latency).
- lap_count: saturates at 2^LAP_CNT_W-1; further LAP commands still recapture the lap registers but do not increment the count.
- Reset mid-operation: rst overrides any state or command in the same cycle, and the pending slot is discarded.

Test Plan:
1. Reset, then btn_runstop pulse -> o_runstop=1 one cycle later. Second pulse -> o_runstop=0. btn_clear from STOP -> o_clear high for exactly 1 cycle, then STOP.
2. In RUN with live time 00:00:05.42, btn_lap -> lap_active=1, disp shows 5 s / 42 while live advances, lap_count=1. btn_clear -> lap_active=0, o_runstop remains 1, no o_clear pulse.
3. In RUN: uart_rx=0x72 with uart_rx_done -> STOP. uart_rx=0x41 ('A') -> no state change and no pending entry. uart_rx=0x63 -> o_clear pulse.
4. In STOP, btn_runstop and UART 'C' in the same cycle -> RUN next cycle. CLEAR executes the following cycle and is ignored in RUN, so o_runstop stays 1. Repeat in LAP_RUN -> LAP_STOP, then STOP with lap_active=0.
5. In RUN, 17 LAP commands with LAP_CNT_W=4 -> lap_count stops at 15; the lap registers hold the 17th snapshot.
6. Assert rst in LAP_RUN with a UART command pending -> next cycle all outputs at reset values and the pending command never executes.
